// File: rtl/ram_io_responder_pkg.sv
// Shared constants for the RAM/IO responder: RAM geometry and the IO window decode.
package ram_io_responder_pkg;

  localparam int RAM_DATA_WIDTH    = 8;
  localparam int RAM_ADDRESS_WIDTH = 17;

  localparam logic [1:0] IO_SEL      = 2'b11;
  localparam logic [2:0] IO_DATA_OFS = 3'd0;
  localparam logic [2:0] IO_HALT_OFS = 3'd4;

  function automatic logic is_io(input logic [1:0] sel);
    return sel == IO_SEL;
  endfunction

endpackage

// File: rtl/ram_io_responder_sync_fifo.sv
// Synchronous FIFO with explicit count; head visible combinationally, push lands next cycle.
// A push into a full FIFO is accepted only alongside a pop; pop of an empty FIFO is ignored.
module ram_io_responder_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dat_o   = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, the write slot equals the head being popped this cycle, so the overwrite is safe.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= dat_i;
  end

endmodule

// File: rtl/ram_io_responder.sv
// RAM + IO-window responder for the byte-serial memory bus; reads return one cycle later.
// IO writes feed a TX FIFO throttled by io_buffer_full; IO_RX_EN adds an RX FIFO read at IO offset 0.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDRESS_WIDTH,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [31:0]               mem_a,
  input  logic [RAM_DATA_WIDTH-1:0] mem_dout,
  input  logic                      mem_wr,
  output logic [RAM_DATA_WIDTH-1:0] mem_din,
  output logic                      io_buffer_full,
  output logic [RAM_DATA_WIDTH-1:0] tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [RAM_DATA_WIDTH-1:0] rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic                      tx_overflow,
  output logic                      sim_halt
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam logic [TXW:0] TX_HI_WM = (TXW+1)'(TX_DEPTH - 1);

  logic       io;
  logic [2:0] ofs;
  logic       ram_wr, ram_rd, io_rd, io_data_wr, io_data_rd, halt_wr;

  assign io         = is_io(mem_a[17:16]);
  assign ofs        = mem_a[2:0];
  assign ram_wr     = rdy && mem_wr && !io;
  assign ram_rd     = rdy && !mem_wr && !io;
  assign io_rd      = rdy && !mem_wr && io;
  assign io_data_wr = rdy && mem_wr && io && (ofs == IO_DATA_OFS);
  assign io_data_rd = io_rd && (ofs == IO_DATA_OFS);
  assign halt_wr    = rdy && mem_wr && io && (ofs == IO_HALT_OFS);

  // RAM read is fully synchronous; the output mux picks RAM or IO data by the last read's source.
  logic [RAM_DATA_WIDTH-1:0] ram_q [2**ADDR_WIDTH];
  logic [RAM_DATA_WIDTH-1:0] ram_dat_q;

  always_ff @(posedge clk) begin
    if (ram_wr) ram_q[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
    if (ram_rd) ram_dat_q <= ram_q[mem_a[ADDR_WIDTH-1:0]];
  end

  logic                      src_ram_q, src_ram_d;
  logic [RAM_DATA_WIDTH-1:0] io_dat_q, io_dat_d;
  logic [RAM_DATA_WIDTH-1:0] rx_rd_dat;

  always_comb begin
    src_ram_d = src_ram_q;
    io_dat_d  = io_dat_q;
    if (ram_rd) begin
      src_ram_d = 1'b1;
    end else if (io_rd) begin
      src_ram_d = 1'b0;
      io_dat_d  = (ofs == IO_DATA_OFS) ? rx_rd_dat : '0;
    end
  end

  assign mem_din = src_ram_q ? ram_dat_q : io_dat_q;

  // TX path
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [TXW:0]  tx_count, tx_count_d;
  logic          io_buffer_full_q, io_buffer_full_d;
  logic          tx_overflow_q, tx_overflow_d;
  logic          sim_halt_q, sim_halt_d;

  assign tx_valid   = !tx_empty;
  assign tx_pop     = rdy && tx_valid && tx_ready;
  assign tx_push    = io_data_wr && (!tx_full || tx_pop);
  assign tx_count_d = tx_count + (TXW+1)'(tx_push) - (TXW+1)'(tx_pop);

  assign io_buffer_full_d = (tx_count_d >= TX_HI_WM);
  assign tx_overflow_d    = tx_overflow_q || (io_data_wr && !tx_push);
  assign sim_halt_d       = sim_halt_q || halt_wr;

  ram_io_responder_sync_fifo #(
    .WIDTH (RAM_DATA_WIDTH),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .dat_i   (mem_dout),
    .pop_i   (tx_pop),
    .dat_o   (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

`ifdef IO_RX_EN
  localparam int RXW = $clog2(RX_DEPTH);

  logic                      rx_push, rx_pop, rx_full, rx_empty;
  logic [RAM_DATA_WIDTH-1:0] rx_head;
  logic [RXW:0]              rx_count;

  assign rx_ready  = !rx_full;
  assign rx_push   = rdy && rx_valid && rx_ready;
  assign rx_pop    = io_data_rd && !rx_empty;
  assign rx_rd_dat = rx_empty ? '0 : rx_head;

  ram_io_responder_sync_fifo #(
    .WIDTH (RAM_DATA_WIDTH),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .dat_i   (rx_data),
    .pop_i   (rx_pop),
    .dat_o   (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  logic unused_rx_count;
  assign unused_rx_count = ^rx_count;
`else
  assign rx_ready  = 1'b0;
  assign rx_rd_dat = '0;

  logic        unused_rx_in;
  logic [31:0] unused_rx_cfg;
  assign unused_rx_in  = ^{rx_data, rx_valid};
  assign unused_rx_cfg = RX_DEPTH;
`endif

  logic unused_addr;
  assign unused_addr = ^mem_a[31:18];

  always_ff @(posedge clk) begin
    if (rst) begin
      src_ram_q        <= 1'b0;
      io_dat_q         <= '0;
      io_buffer_full_q <= 1'b0;
      tx_overflow_q    <= 1'b0;
      sim_halt_q       <= 1'b0;
    end else begin
      src_ram_q        <= src_ram_d;
      io_dat_q         <= io_dat_d;
      io_buffer_full_q <= io_buffer_full_d;
      tx_overflow_q    <= tx_overflow_d;
      sim_halt_q       <= sim_halt_d;
    end
  end

  assign io_buffer_full = io_buffer_full_q;
  assign tx_overflow    = tx_overflow_q;
  assign sim_halt       = sim_halt_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: expected read bytes and TX bytes are queued by stimulus, checked by a monitor.
module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [31:0] mem_a = 32'h0003_0005;
  logic [7:0]  mem_dout = 8'h00;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        tx_overflow;
  logic        sim_halt;

  logic        chk_rd = 1'b0;
  logic [7:0]  rd_exp[$];
  logic [7:0]  tx_exp[$];
  int          n_cmp = 0;
  int          n_err = 0;

  ram_io_responder dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_overflow    (tx_overflow),
    .sim_halt       (sim_halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: a read sampled at an edge is compared #1 later; a TX handshake compares the byte it took.
  always @(posedge clk) begin
    logic       was_rd, was_pop;
    logic [7:0] popped;
    was_rd  = chk_rd && rdy && !mem_wr && !rst;
    was_pop = tx_valid && tx_ready && rdy && !rst;
    popped  = tx_data;
    #1;
    if (was_rd) begin
      if (rd_exp.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rd_unexpected: got %02h expected none", mem_din);
      end else begin
        check("mem_din", mem_din, rd_exp.pop_front());
      end
    end
    if (was_pop) begin
      if (tx_exp.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL tx_unexpected: got %02h expected none", popped);
      end else begin
        check("tx_data", popped, tx_exp.pop_front());
      end
    end
  end

  // All tasks start and end at a falling edge; each consumes exactly one rising edge.
  task automatic wr(input logic [31:0] a, input logic [7:0] d, input bit push_tx);
    mem_a = a; mem_dout = d; mem_wr = 1'b1; chk_rd = 1'b0;
    if (push_tx) tx_exp.push_back(d);
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp);
    mem_a = a; mem_wr = 1'b0; chk_rd = 1'b1;
    rd_exp.push_back(exp);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    mem_a = 32'h0003_0005; mem_wr = 1'b0; chk_rd = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_mem_din", mem_din, 8'h00);
    check("rst_ibf", {7'd0, io_buffer_full}, 8'h00);
    check("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    check("rst_tx_overflow", {7'd0, tx_overflow}, 8'h00);
    check("rst_sim_halt", {7'd0, sim_halt}, 8'h00);
`ifdef IO_RX_EN
    check("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
`else
    check("rst_rx_ready", {7'd0, rx_ready}, 8'h00);
`endif

    // RAM round trip, back-to-back
    wr(32'h100, 8'hEF, 0); wr(32'h101, 8'hBE, 0); wr(32'h102, 8'hAD, 0); wr(32'h103, 8'hDE, 0);
    rd(32'h100, 8'hEF); rd(32'h101, 8'hBE); rd(32'h102, 8'hAD); rd(32'h103, 8'hDE);
    wr(32'h200, 8'h5A, 0);
    rd(32'h200, 8'h5A);
    wr(32'h0003_0005, 8'hFF, 0);
    check("hold_on_write", mem_din, 8'h5A);
    rd(32'h0003_0002, 8'h00);
    rd(32'h0003_0000, 8'h00);

    // TX back-pressure
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr(32'h0003_0000, 8'(8'h10 + i), 1);
      if (i == 5) check("ibf_at_6", {7'd0, io_buffer_full}, 8'h00);
    end
    check("ibf_at_7", {7'd0, io_buffer_full}, 8'h01);
    check("tx_valid_after_push", {7'd0, tx_valid}, 8'h01);
    check("tx_head", tx_data, 8'h10);
    wr(32'h0003_0000, 8'h17, 1);
    check("ovf_after_8th", {7'd0, tx_overflow}, 8'h00);
    tx_ready = 1'b1;
    wr(32'h0003_0000, 8'h19, 1);
    tx_ready = 1'b0;
    check("ovf_push_pop_full", {7'd0, tx_overflow}, 8'h00);
    check("ibf_push_pop_full", {7'd0, io_buffer_full}, 8'h01);
    wr(32'h0003_0000, 8'h1A, 0);
    check("ovf_after_drop", {7'd0, tx_overflow}, 8'h01);
    tx_ready = 1'b1;
    idle(10);
    check("tx_valid_drained", {7'd0, tx_valid}, 8'h00);
    check("ibf_drained", {7'd0, io_buffer_full}, 8'h00);
    tx_ready = 1'b0;

    // Halt register
    wr(32'h0003_0004, 8'h00, 0);
    check("sim_halt_set", {7'd0, sim_halt}, 8'h01);
    idle(3);
    check("sim_halt_sticky", {7'd0, sim_halt}, 8'h01);

    // rdy low freezes RAM writes, mem_din and TX pops
    wr(32'h300, 8'h77, 0);
    rdy = 1'b0;
    wr(32'h300, 8'h99, 0);
    rdy = 1'b1;
    rd(32'h300, 8'h77);
    rdy = 1'b0;
    mem_a = 32'h100; mem_wr = 1'b0; chk_rd = 1'b0;
    @(negedge clk);
    check("rdy_low_hold", mem_din, 8'h77);
    rdy = 1'b1;
    wr(32'h0003_0000, 8'h21, 1); wr(32'h0003_0000, 8'h22, 1); wr(32'h0003_0000, 8'h23, 1);
    rdy = 1'b0;
    tx_ready = 1'b1;
    idle(2);
    check("rdy_low_tx_valid", {7'd0, tx_valid}, 8'h01);
    check("rdy_low_no_pop", tx_data, 8'h21);

    // Reset with 3 bytes queued discards them
    tx_ready = 1'b0;
    rdy = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_exp.delete();
    check("rst2_tx_valid", {7'd0, tx_valid}, 8'h00);
    check("rst2_mem_din", mem_din, 8'h00);
    check("rst2_sim_halt", {7'd0, sim_halt}, 8'h00);
    check("rst2_tx_overflow", {7'd0, tx_overflow}, 8'h00);

`ifdef IO_RX_EN
    rx_valid = 1'b1; rx_data = 8'h41;
    idle(1);
    rx_data = 8'h42;
    idle(1);
    rx_valid = 1'b0;
    rd(32'h0003_0000, 8'h41);
    rd(32'h0003_0000, 8'h42);
    rd(32'h0003_0000, 8'h00);
`endif

    idle(3);
    check("rd_queue_empty", 8'(rd_exp.size()), 8'h00);
    check("tx_queue_empty", 8'(tx_exp.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_io_responder.md
# ram_io_responder

Memory-side responder for the byte-serial RAM/IO bus driven by the memory controller. It holds the program/data RAM and decodes the IO window at address bits [17:16] == 2'b11 into a UART transmit FIFO, an optional receive FIFO and a simulation-halt register. It returns read bytes one cycle after the address is presented, and reports TX back-pressure via io_buffer_full.

## Interface
- ADDR_WIDTH, 17: RAM address bits; RAM holds 2^ADDR_WIDTH bytes.
- TX_DEPTH, 8: TX FIFO entries; must be a power of two and at least 4.
- RX_DEPTH, 8: RX FIFO entries; must be a power of two and at least 2. Used only with IO_RX_EN.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global enable. Low freezes all state.
- mem_a  in  32  byte address from the controller.
- mem_dout  in  8  write byte from the controller.
- mem_wr  in  1  1 = write, 0 = read.
- mem_din  out  8  read byte returned to the controller.
- io_buffer_full  out  1  TX FIFO almost full; the controller must hold IO writes.
- tx_data  out  8  head byte of the TX FIFO.
- tx_valid  out  1  TX FIFO is non-empty.
- tx_ready  in  1  the UART consumes tx_data.
- rx_data  in  8  incoming byte (IO_RX_EN only).
- rx_valid  in  1  rx_data is valid (IO_RX_EN only).
- rx_ready  out  1  RX FIFO is not full (IO_RX_EN only).
- tx_overflow  out  1  sticky flag: an IO write was dropped.
- sim_halt  out  1  sticky flag: the halt register was written.

## Operation
- Decode:
  - io = (mem_a[17:16] == 2'b11).
  - RAM index = mem_a[ADDR_WIDTH-1:0].
  - IO offset = mem_a[2:0]. Offset 0 is data; offset 4 is halt; other offsets read 0x00 and ignore writes.
- RAM write: when rdy && mem_wr && !io, ram[index] <= mem_dout.
- RAM read: when rdy && !mem_wr && !io, mem_din <= ram[index].
- IO write at offset 0:
  - Push mem_dout into the TX FIFO if count < TX_DEPTH, or if a pop happens in the same cycle.
  - Otherwise drop the byte and set tx_overflow.
- IO write at offset 4: set sim_halt. It stays set until rst.
- IO read at offset 0 with IO_RX_EN:
  - RX non-empty: mem_din <= RX head and pop in the same cycle.
  - RX empty: mem_din <= 0x00 and no pop.
- IO read at offset 0 without IO_RX_EN: mem_din <= 0x00.
- IO write: mem_din holds its previous value.
- TX pop: when tx_valid && tx_ready. Push and pop in the same cycle leave count unchanged.
- RX push (IO_RX_EN): when rx_valid && rx_ready.
- io_buffer_full = (tx_count >= TX_DEPTH-1). It is registered from the next-state count. The one-entry margin absorbs a write already on the bus.
- rdy low:
  - No RAM write, no FIFO push or pop, mem_din holds.
  - tx_valid, tx_data and rx_ready still reflect the stored state.
  - No pop happens while rdy is low, even if tx_ready is high.

## Timing
- Read latency is 1 cycle. Address presented at edge n gives mem_din valid after edge n+1. A new address every cycle gives back-to-back bytes.
- Write takes effect at the edge where mem_wr is sampled. A read of the same address in the next cycle returns the new byte.
- TX push-to-tx_valid latency is 1 cycle.
- io_buffer_full updates 1 cycle after the push or pop that changes the count.
- Reset values:
  - mem_din = 0x00, io_buffer_full = 0, tx_valid = 0, rx_ready = 1.
  - tx_overflow = 0, sim_halt = 0.
  - FIFO pointers and counts = 0.
  - RAM contents are not reset.
- Reset mid-stream discards all FIFO contents. An in-flight read returns 0x00.
- FIFO pointers wrap modulo depth. A full/empty ambiguity cannot occur because of an explicit count register of log2(depth)+1 bits.

## Configuration
- IO_RX_EN defined:
  - RX FIFO instantiated.
  - rx_data, rx_valid and rx_ready are active.
  - IO offset 0 reads pop the RX FIFO.
- IO_RX_EN undefined:
  - No RX FIFO.
  - rx_ready is tied 0; rx_data and rx_valid are ignored.
  - IO offset 0 reads return 0x00.

## Structure
- Shared constants go in constant.v:
  - IO_SEL = 2'b11.
  - IO_DATA_OFS = 3'd0, IO_HALT_OFS = 3'd4.
  - Existing RAM_DATA_WIDTH and RAM_ADDRESS_WIDTH.
- One sub-module, sync_fifo:
  - Parameters: width, depth.
  - Ports: push, pop, full, empty, count.
  - Instanced once for TX and once for RX (RX only under IO_RX_EN).

## Test plan
- RAM round trip: write 0xEF,0xBE,0xAD,0xDE to 0x00100..0x00103 on consecutive cycles, then read them back on consecutive cycles -> mem_din = 0xEF,0xBE,0xAD,0xDE, each one cycle after its address.
- TX back-pressure: tx_ready=0, 7 writes to 0x30000 -> io_buffer_full rises 1 cycle after the 7th. An 8th write is accepted and a 9th sets tx_overflow. Then tx_ready=1 -> bytes drain in order.
- Simultaneous push/pop at full: count=8, IO write while tx_ready=1 -> count stays 8, tx_overflow stays 0.
- Halt: write 0x00 to 0x30004 -> sim_halt=1 on the next cycle, and it persists until rst.
- RX (IO_RX_EN): push 0x41,0x42, then read 0x30000 twice -> mem_din = 0x41, then 0x42. A third read gives 0x00.
- rdy/reset: rdy=0 during a RAM write -> memory is unchanged. rst with 3 bytes in TX -> tx_valid=0 on the next cycle.
